muldiv_seq: RTL
===============

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the execute-stage ALU.
//  Accepts one M-extension op per instruction in E and runs a 32-step shift-add or restoring-divide loop.
//  Holds the instruction in E by asserting StallMD to the hazard unit until the result is ready.
//  The result joins the ALUResultE mux in the DONE cycle.
// PARAMETERS
//  XLEN   32  operand/result width (only 32 supported)
//  CNT_W  5   iteration counter width; XLEN = 2**CNT_W
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous reset, active-high
//  MulDivE        in   1     instruction in E is an M-extension op (valid)
//  MulDivOpE      in   3     funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//  SrcAE          in   XLEN  forwarded rs1 value
//  SrcBE          in   XLEN  forwarded rs2 value
//  FlushE         in   1     kill instruction in E (branch/jump redirect)
//  HoldE          in   1     E held by another stall source; do not retire result
//  StallMD        out  1     stall F/D/E; instruction must stay in E
//  DoneMD         out  1     result valid this cycle; instruction may leave E
//  MulDivResultE  out  XLEN  result; valid only while DoneMD=1
// BEHAVIOUR
//  Reset: state=IDLE; StallMD=0; DoneMD=0; MulDivResultE=0; count=0; all operand/accumulator regs=0.
//  Reset wins over every other input in any state; an in-flight op is discarded.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE:
//   - MulDivE=1 & FlushE=0: latch op and operand magnitudes, plus sign flags per op.
//     Signed: MULH (both), MULHSU (A only), DIV/REM (both).
//   - Next state: MUL (op<4), DIV (op>=4), count=0.
//   - Special divides go straight to DONE with a precomputed result:
//     div-by-zero gives quotient 0xFFFFFFFF, remainder = SrcAE.
//     Signed overflow (0x80000000 / -1) gives quotient 0x80000000, remainder 0.
//  StallMD = (IDLE & MulDivE & ~FlushE) | MUL | DIV. It is combinational so the start cycle itself stalls.
//  MUL: one shift-add step per cycle on unsigned magnitudes into a 64-bit product; count++.
//   At count=31 the state goes to DONE. Sign fixed on exit: negate 64b if sign flags differ.
//   Result: MUL = low 32; MULH/MULHSU/MULHU = high 32.
//  DIV: one restoring step per cycle (shift remainder, trial-subtract, set quotient bit); count++.
//   At count=31 the state goes to DONE.
//   Signed fix: quotient negated if signs differ; remainder takes dividend sign.
//   Result: DIV/DIVU = quotient; REM/REMU = remainder.
//  DONE: DoneMD=1, StallMD=0, MulDivResultE valid.
//   - HoldE=1: stay in DONE, result and DoneMD held stable.
//   - Otherwise next state is IDLE. The op is never restarted on the same instruction.
//  Latency, normal op: 1 start cycle + 32 iterations stalled (33 cycles StallMD=1); DoneMD on cycle 34.
//  Latency, special divide: 1 cycle StallMD=1; DoneMD on cycle 2.
//  FlushE=1 in any state: next state IDLE. No DoneMD; StallMD drops the same cycle.
//   Flush has priority over a start in IDLE.
//  MulDivE deasserting mid-operation does not abort; only FlushE or rst aborts.
//  All arithmetic is modulo 2^XLEN, with no exceptions (per RV32M). x0 writeback is handled downstream.
//  Counter wraps 31->0 only on the DONE transition; count is never read outside MUL/DIV.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB; StallMD high exactly 33 cycles; DoneMD one cycle on cycle 34.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF.
//  3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  4. DIVU 0x1234/0 -> 0xFFFFFFFF and REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//     All with a 1-cycle stall.
//  5. FlushE at iteration 10 -> IDLE next cycle, no DoneMD, StallMD low.
//     Following MUL 3*5 -> 15 with full latency. rst mid-DIV -> all outputs 0 next cycle.
//  6. HoldE=1 for 4 cycles in DONE -> DoneMD and result stable; the single IDLE return happens after HoldE drops.
//     Back-to-back ops each complete correctly.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sitting beside the execute-stage ALU.
// One shift-add (multiply) or restoring (divide) step per cycle on operand
// magnitudes, with sign correction applied on the final iteration.
//
// state | meaning
// IDLE  | waiting for an M-extension op in E
// MUL   | 32 shift-add iterations on magnitudes
// DIV   | 32 restoring-divide iterations on magnitudes
// DONE  | result presented, instruction may leave E
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MulDivE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  input  logic            HoldE,
  output logic            StallMD,
  output logic            DoneMD,
  output logic [XLEN-1:0] MulDivResultE
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic              sa_q, sb_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] prod_q;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   res_q;

  logic              start, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special, last;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, mul_fix;
  logic [XLEN-1:0]   mul_res, quo_fix, rem_fix, div_res;

  // Operand decode: sign flags, magnitudes and the divide corner cases
  always_comb begin
    start    = MulDivE & ~FlushE;
    a_signed = (MulDivOpE == 3'd1) | (MulDivOpE == 3'd2) |
               (MulDivOpE == 3'd4) | (MulDivOpE == 3'd6);
    b_signed = (MulDivOpE == 3'd1) | (MulDivOpE == 3'd4) | (MulDivOpE == 3'd6);
    a_neg    = a_signed & SrcAE[XLEN-1];
    b_neg    = b_signed & SrcBE[XLEN-1];
    a_mag    = a_neg ? -SrcAE : SrcAE;
    b_mag    = b_neg ? -SrcBE : SrcBE;
    div_zero = MulDivOpE[2] & (SrcBE == '0);
    div_ovf  = MulDivOpE[2] & ~MulDivOpE[0] & (SrcAE == MIN_NEG) & (SrcBE == '1);
    special  = div_zero | div_ovf;
    // op[1] selects remainder for divides
    if (div_zero) spec_res = MulDivOpE[1] ? SrcAE : '1;
    else          spec_res = MulDivOpE[1] ? '0 : MIN_NEG;
  end

  // One iteration of each loop, plus sign fix-up of the final step's value
  always_comb begin
    // multiplier sits in the low half and shifts out as the product shifts in
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    // remainder in the high half, dividend shifts out of / quotient into the low half
    div_shift = prod_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    last      = (count_q == CNT_LAST);
    mul_fix   = (sa_q ^ sb_q) ? -mul_next : mul_next;
    mul_res   = (op_q == 2'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    quo_fix   = (sa_q ^ sb_q) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem_fix   = sa_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; a flush drops stall/done in the same cycle
  always_comb begin
    state_d = state_q;
    StallMD = 1'b0;
    DoneMD  = 1'b0;
    case (state_q)
      S_IDLE: begin
        StallMD = start;
        if (start) begin
          if (special)           state_d = S_DONE;
          else if (MulDivOpE[2]) state_d = S_DIV;
          else                   state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        StallMD = ~FlushE;
        if (FlushE)    state_d = S_IDLE;
        else if (last) state_d = S_DONE;
      end
      S_DONE: begin
        DoneMD = ~FlushE;
        if (FlushE || !HoldE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    MulDivResultE = DoneMD ? res_q : '0;
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      count_q <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= MulDivOpE[1:0];
            sa_q    <= a_neg;
            sb_q    <= b_neg;
            opnd_q  <= b_mag;
            prod_q  <= {{XLEN{1'b0}}, a_mag};
            count_q <= '0;
            if (special) res_q <= spec_res;
          end
        end
        S_MUL: begin
          if (!FlushE) begin
            prod_q  <= mul_next;
            count_q <= count_q + CNT_ONE;
            if (last) res_q <= mul_res;
          end
        end
        S_DIV: begin
          if (!FlushE) begin
            prod_q  <= div_next;
            count_q <= count_q + CNT_ONE;
            if (last) res_q <= div_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
